// File: rtl/rgmii_tx_pkg.sv
// rgmii_tx_pkg: speed encodings, default divisors and shared helpers for the RGMII transmit path
package rgmii_tx_pkg;
  localparam logic [1:0] SPEED_10 = 2'b00;
  localparam logic [1:0] SPEED_100 = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;
  localparam int DIV_100_DEF = 5;
  localparam int DIV_10_DEF = 50;
  localparam int CNT_W_DEF = 6;
  typedef struct packed {
    logic en;
    logic er;
    logic [7:0] d;
  } tx_byte_t;
  function automatic int half_of(input int div);
    return div / 2;
  endfunction
  function automatic logic is_gig(input logic [1:0] s);
    return s[1];
  endfunction
endpackage

// File: rtl/rgmii_tx_clk_gen.sv
// rgmii_tx_clk_gen: cnt/nib sequencer producing forwarded clock levels, update point and byte strobe
module rgmii_tx_clk_gen import rgmii_tx_pkg::*; #(
  parameter int DIV_100 = DIV_100_DEF,
  parameter int DIV_10 = DIV_10_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  input logic [1:0] spd,
  input logic [1:0] spd_nxt,
  output logic nib_nxt,
  output logic upd_nxt,
  output logic mac_clk_en,
  output logic clk_q1,
  output logic clk_q2
);
  logic [CNT_W-1:0] cnt, cnt_nxt, div_m1, half;
  logic [CNT_W:0] div_w;
  logic nib, gig_nxt, from_gig;
  always_comb begin
    gig_nxt = is_gig(spd_nxt);
    from_gig = is_gig(spd);
    div_w = spd_nxt == SPEED_10 ? (CNT_W+1)'(DIV_10) : (CNT_W+1)'(DIV_100);
    div_m1 = spd_nxt == SPEED_10 ? CNT_W'(DIV_10 - 1) : CNT_W'(DIV_100 - 1);
    half = spd_nxt == SPEED_10 ? CNT_W'(half_of(DIV_10)) : CNT_W'(half_of(DIV_100));
    // a strobe edge always lands on the update point of the (possibly new) rate
    cnt_nxt = (gig_nxt || from_gig) ? '0 : mac_clk_en ? half : cnt == div_m1 ? '0 : cnt + CNT_W'(1);
    upd_nxt = !gig_nxt && !from_gig && cnt_nxt == half;
    nib_nxt = gig_nxt ? 1'b0 : from_gig ? 1'b1 : nib ^ upd_nxt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      nib <= 1'b0;
      mac_clk_en <= 1'b0;
      clk_q1 <= 1'b0;
      clk_q2 <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      nib <= nib_nxt;
      mac_clk_en <= gig_nxt || (cnt_nxt == half - CNT_W'(1) && nib_nxt);
      clk_q1 <= gig_nxt || {cnt_nxt, 1'b0} < div_w;
      clk_q2 <= !gig_nxt && {cnt_nxt, 1'b1} < div_w;
    end
endmodule

// File: rtl/rgmii_tx_ddr_gen.sv
// rgmii_tx_ddr_gen: GMII byte stream to per-edge RGMII data/control/clock patterns at 1000/100/10 Mb/s
module rgmii_tx_ddr_gen import rgmii_tx_pkg::*; #(
  parameter int DIV_100 = DIV_100_DEF,
  parameter int DIV_10 = DIV_10_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  input logic [1:0] speed,
  input logic [7:0] gmii_txd,
  input logic gmii_tx_en,
  input logic gmii_tx_er,
  output logic mac_clk_en,
  output logic [3:0] ddr_d_q1,
  output logic [3:0] ddr_d_q2,
  output logic ddr_ctl_q1,
  output logic ddr_ctl_q2,
  output logic ddr_clk_q1,
  output logic ddr_clk_q2
);
  logic [1:0] spd, spd_nxt;
  logic nib_nxt, upd_nxt, gig_nxt;
  logic [3:0] nib_d;
  tx_byte_t byte_r, byte_src;
  always_comb begin
    spd_nxt = mac_clk_en ? speed : spd;
    gig_nxt = is_gig(spd_nxt);
    byte_src = (mac_clk_en || gig_nxt) ? {gmii_tx_en, gmii_tx_er, gmii_txd} : byte_r;
    nib_d = nib_nxt ? byte_src.d[7:4] : byte_src.d[3:0];
  end
  rgmii_tx_clk_gen #(.DIV_100(DIV_100), .DIV_10(DIV_10), .CNT_W(CNT_W)) u_clk_gen (
    .clk(clk),
    .rst_n(rst_n),
    .spd(spd),
    .spd_nxt(spd_nxt),
    .nib_nxt(nib_nxt),
    .upd_nxt(upd_nxt),
    .mac_clk_en(mac_clk_en),
    .clk_q1(ddr_clk_q1),
    .clk_q2(ddr_clk_q2)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spd <= SPEED_1000;
      byte_r <= '0;
      ddr_d_q1 <= '0;
      ddr_d_q2 <= '0;
      ddr_ctl_q1 <= 1'b0;
      ddr_ctl_q2 <= 1'b0;
    end else begin
      spd <= spd_nxt;
      byte_r <= byte_src;
      if (gig_nxt || upd_nxt) begin
        ddr_d_q1 <= nib_d;
        ddr_d_q2 <= gig_nxt ? byte_src.d[7:4] : nib_d;
        ddr_ctl_q1 <= byte_src.en;
        ddr_ctl_q2 <= byte_src.en ^ byte_src.er;
      end
    end
endmodule
